// File: rtl/prog_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// prog_ctrl_pkg
// Shared definitions for the program run controller:
//   PC_W       - program counter / branch target width
//   NUM_PROGS  - number of selectable programs
//   run_state_t- run controller states
//   tgt_mode_t - how pc_target_calc forms the relative PcTarget
//   PROG_BASE  - start address of each selectable program
// -----------------------------------------------------------------------------
package prog_ctrl_pkg;

    localparam int PC_W      = 10;
    localparam int NUM_PROGS = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARMED  = 3'd1,
        LAUNCH = 3'd2,
        RUN    = 3'd3,
        DONE   = 3'd4
    } run_state_t;

    typedef enum logic [1:0] {
        TM_NONE   = 2'd0,
        TM_LAUNCH = 2'd1,
        TM_ABS    = 2'd2,
        TM_REL    = 2'd3
    } tgt_mode_t;

    localparam logic [PC_W-1:0] PROG_BASE [NUM_PROGS] = '{10'd0, 10'd128, 10'd256, 10'd384};

endpackage

// File: rtl/prog_run_ctrl_if.sv
// -----------------------------------------------------------------------------
// prog_run_ctrl_if
// Bundle between the test harness / decoder / ProgCtr and the run controller.
//   Harness/decoder -> controller : Start, ProgSel, CurPc, BrTaken, BrAbs,
//                                   BrTarget, Halt, Stall
//   Controller -> ProgCtr/harness : PcBranch, PcTarget, PcHold, Running, Done,
//                                   ActiveProg, CycleCount
// master drives the requests, slave is the controller.
// -----------------------------------------------------------------------------
interface prog_run_ctrl_if #(
    parameter int PC_W      = prog_ctrl_pkg::PC_W,
    parameter int CNT_W     = 16,
    parameter int NUM_PROGS = prog_ctrl_pkg::NUM_PROGS
);
    localparam int SEL_W = $clog2(NUM_PROGS);

    logic             Start;
    logic [SEL_W-1:0] ProgSel;
    logic [PC_W-1:0]  CurPc;
    logic             BrTaken;
    logic             BrAbs;
    logic [PC_W-1:0]  BrTarget;
    logic             Halt;
    logic             Stall;

    logic             PcBranch;
    logic [PC_W-1:0]  PcTarget;
    logic             PcHold;
    logic             Running;
    logic             Done;
    logic [SEL_W-1:0] ActiveProg;
    logic [CNT_W-1:0] CycleCount;

    modport master (
        output Start, ProgSel, CurPc, BrTaken, BrAbs, BrTarget, Halt, Stall,
        input  PcBranch, PcTarget, PcHold, Running, Done, ActiveProg, CycleCount
    );

    modport slave (
        input  Start, ProgSel, CurPc, BrTaken, BrAbs, BrTarget, Halt, Stall,
        output PcBranch, PcTarget, PcHold, Running, Done, ActiveProg, CycleCount
    );

endinterface

// File: rtl/prog_run_ctrl_pc_target_calc.sv
// -----------------------------------------------------------------------------
// pc_target_calc
// Combinational conversion of a launch base or a branch target into the
// relative offset ProgCtr adds to its PC.
//   mode_i   : TM_NONE -> 0, TM_LAUNCH/TM_ABS -> tgt_i - cur_pc_i,
//              TM_REL -> tgt_i unchanged
//   tgt_i    : program base (launch) or branch target/offset
//   cur_pc_i : current ProgCtr value
//   target_o : relative PcTarget, modulo 2^PC_W
// -----------------------------------------------------------------------------
module pc_target_calc #(
    parameter int PC_W = prog_ctrl_pkg::PC_W
) (
    input  prog_ctrl_pkg::tgt_mode_t mode_i,
    input  logic [PC_W-1:0]          tgt_i,
    input  logic [PC_W-1:0]          cur_pc_i,
    output logic [PC_W-1:0]          target_o
);
    import prog_ctrl_pkg::*;

    always_comb begin
        target_o = '0;
        case (mode_i)
            // Absolute destinations become PC-relative; wrap is intentional.
            TM_LAUNCH, TM_ABS: target_o = tgt_i - cur_pc_i;
            TM_REL:            target_o = tgt_i;
            default:           target_o = '0;
        endcase
    end

endmodule

// File: rtl/prog_run_ctrl.sv
// -----------------------------------------------------------------------------
// prog_run_ctrl
// Run controller sequencing the instruction-fetch program counter.
// Holds the PC while idle, launches the selected program when Start is
// released, converts decoder branches into relative ProgCtr offsets, and on
// Halt freezes fetch and reports Done with the number of RUN cycles.
//   Clk   : clock, rising edge
//   Reset : synchronous, active-high
//   bus   : prog_run_ctrl_if slave (handshake, decoder requests, ProgCtr
//           controls, status)
// -----------------------------------------------------------------------------
module prog_run_ctrl #(
    parameter int PC_W      = prog_ctrl_pkg::PC_W,
    parameter int CNT_W     = 16,
    parameter int NUM_PROGS = prog_ctrl_pkg::NUM_PROGS
) (
    input  logic           Clk,
    input  logic           Reset,
    prog_run_ctrl_if.slave bus
);
    import prog_ctrl_pkg::*;

    localparam int SEL_W = $clog2(NUM_PROGS);

    localparam logic [2:0] S_IDLE   = IDLE;
    localparam logic [2:0] S_ARMED  = ARMED;
    localparam logic [2:0] S_LAUNCH = LAUNCH;
    localparam logic [2:0] S_RUN    = RUN;
    localparam logic [2:0] S_DONE   = DONE;

    logic [2:0]       state_q, state_d;
    logic [SEL_W-1:0] prog_q, prog_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    tgt_mode_t        mode;
    logic             hold, branch;
    logic [PC_W-1:0]  tgt_sel, tgt_calc;

    always_comb begin
        state_d = state_q;
        prog_d  = prog_q;
        cnt_d   = cnt_q;
        mode    = TM_NONE;
        hold    = 1'b1;
        branch  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.Start) begin
                    state_d = S_ARMED;
                    prog_d  = bus.ProgSel;
                end
            end
            S_ARMED: begin
                // Launch happens on the release of Start, not its assertion.
                if (!bus.Start) state_d = S_LAUNCH;
            end
            S_LAUNCH: begin
                hold    = 1'b0;
                branch  = 1'b1;
                mode    = TM_LAUNCH;
                cnt_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                // Halt beats Stall beats BrTaken; a stalled branch is dropped.
                if (bus.Halt) begin
                    state_d = S_DONE;
                end else if (bus.Stall) begin
                    hold = 1'b1;
                end else if (bus.BrTaken) begin
                    hold   = 1'b0;
                    branch = 1'b1;
                    mode   = bus.BrAbs ? TM_ABS : TM_REL;
                end else begin
                    hold = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign tgt_sel = (mode == TM_LAUNCH) ? PC_W'(PROG_BASE[prog_q]) : bus.BrTarget;

    pc_target_calc #(.PC_W(PC_W)) u_tgt (
        .mode_i   (mode),
        .tgt_i    (tgt_sel),
        .cur_pc_i (bus.CurPc),
        .target_o (tgt_calc)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            prog_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            prog_q  <= prog_d;
            cnt_q   <= cnt_d;
        end
    end

    // Reset also freezes ProgCtr in the same cycle it is asserted.
    assign bus.PcHold     = Reset ? 1'b1 : hold;
    assign bus.PcBranch   = Reset ? 1'b0 : branch;
    assign bus.PcTarget   = (Reset || !branch) ? '0 : tgt_calc;
    assign bus.Running    = (state_q == S_RUN);
    assign bus.Done       = (state_q == S_DONE);
    assign bus.ActiveProg = prog_q;
    assign bus.CycleCount = cnt_q;

endmodule

// File: tb/tb_prog_run_ctrl.sv
module tb_prog_run_ctrl;

    localparam int PC_W  = 10;
    localparam int CNT_W = 16;
    localparam int NPROG = 4;
    localparam int PC_MOD  = 1 << PC_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    localparam int PH_IDLE   = 0;
    localparam int PH_ARMED  = 1;
    localparam int PH_LAUNCH = 2;
    localparam int PH_RUN    = 3;
    localparam int PH_DONE   = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;

    // Reference model: controller phase, latched program, run-cycle count.
    int m_ph   = PH_IDLE;
    int m_prog = 0;
    int m_cnt  = 0;

    always #5 clk = ~clk;

    prog_run_ctrl_if #(.PC_W(PC_W), .CNT_W(CNT_W), .NUM_PROGS(NPROG)) bus ();

    prog_run_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W), .NUM_PROGS(NPROG)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    function automatic int wrap(input int x);
        return ((x % PC_MOD) + PC_MOD) % PC_MOD;
    endfunction

    // Program n starts at n*128.
    function automatic int prog_base(input int p);
        return p * 128;
    endfunction

    function automatic int exp_branch();
        if (rst) return 0;
        if (m_ph == PH_LAUNCH) return 1;
        if (m_ph == PH_RUN && !bus.Halt && !bus.Stall && bus.BrTaken) return 1;
        return 0;
    endfunction

    function automatic int exp_hold();
        if (rst) return 1;
        if (m_ph == PH_LAUNCH) return 0;
        if (m_ph == PH_RUN) return (bus.Halt || bus.Stall) ? 1 : 0;
        return 1;
    endfunction

    function automatic int exp_target();
        if (exp_branch() == 0) return 0;
        if (m_ph == PH_LAUNCH) return wrap(prog_base(m_prog) - int'(bus.CurPc));
        if (bus.BrAbs) return wrap(int'(bus.BrTarget) - int'(bus.CurPc));
        return int'(bus.BrTarget);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        #1;
        chk({tag, ".PcHold"},     32'(bus.PcHold),     32'(exp_hold()));
        chk({tag, ".PcBranch"},   32'(bus.PcBranch),   32'(exp_branch()));
        chk({tag, ".PcTarget"},   32'(bus.PcTarget),   32'(exp_target()));
        chk({tag, ".Running"},    32'(bus.Running),    32'(m_ph == PH_RUN));
        chk({tag, ".Done"},       32'(bus.Done),       32'(m_ph == PH_DONE));
        chk({tag, ".ActiveProg"}, 32'(bus.ActiveProg), 32'(m_prog));
        chk({tag, ".CycleCount"}, 32'(bus.CycleCount), 32'(m_cnt));
    endtask

    task automatic model_step();
        if (rst) begin
            m_ph = PH_IDLE; m_prog = 0; m_cnt = 0;
        end else begin
            case (m_ph)
                PH_IDLE, PH_DONE: if (bus.Start) begin m_ph = PH_ARMED; m_prog = int'(bus.ProgSel); end
                PH_ARMED:  if (!bus.Start) m_ph = PH_LAUNCH;
                PH_LAUNCH: begin m_cnt = 0; m_ph = PH_RUN; end
                PH_RUN: begin
                    if (m_cnt < CNT_MAX) m_cnt++;
                    if (bus.Halt) m_ph = PH_DONE;
                end
                default: m_ph = PH_IDLE;
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic quiet();
        bus.Start = 0; bus.BrTaken = 0; bus.BrAbs = 0; bus.BrTarget = '0;
        bus.Halt = 0; bus.Stall = 0;
    endtask

    task automatic branch_in(input int pc, input int abs_m, input int tgt);
        quiet();
        bus.CurPc = PC_W'(pc); bus.BrTaken = 1; bus.BrAbs = abs_m[0]; bus.BrTarget = PC_W'(tgt);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        quiet();
        bus.ProgSel = '0;
        bus.CurPc   = '0;

        // Reset with Start held high
        bus.Start = 1;
        tick();
        tick();
        rst = 1'b0;
        bus.Start = 0;
        check_all("reset");
        chk("reset_hold", 32'(bus.PcHold), 1);

        // Arm program 2; ProgSel change while armed is ignored
        bus.ProgSel = 2'd2; bus.Start = 1;
        check_all("idle_start");
        tick();
        bus.ProgSel = 2'd1;
        check_all("armed1");
        tick();
        bus.Start = 0; bus.CurPc = PC_W'(5);
        check_all("armed2");
        tick();
        check_all("launch");
        chk("launch_tgt", 32'(bus.PcTarget), 251);
        chk("launch_br", 32'(bus.PcBranch), 1);
        tick();

        // Branch conversion
        branch_in(260, 0, 10);
        check_all("br_rel");
        chk("br_rel_tgt", 32'(bus.PcTarget), 10);
        chk("run_prog", 32'(bus.ActiveProg), 2);
        tick();
        branch_in(260, 1, 300);
        check_all("br_abs");
        chk("br_abs_tgt", 32'(bus.PcTarget), 40);
        tick();
        branch_in(300, 1, 256);
        check_all("br_wrap");
        chk("br_wrap_tgt", 32'(bus.PcTarget), 980);
        tick();

        // Priority
        branch_in(100, 0, 7); bus.Stall = 1;
        check_all("stall_br");
        chk("stall_br_hold", 32'(bus.PcHold), 1);
        tick();
        quiet();
        check_all("seq");
        tick();
        branch_in(100, 1, 50); bus.Stall = 1; bus.Halt = 1;
        check_all("halt_br");
        tick();
        quiet();
        check_all("done1");
        chk("done1_flag", 32'(bus.Done), 1);

        // Restart from DONE, run 7 cycles with Halt on the 7th
        bus.Start = 1; bus.ProgSel = 2'd3;
        tick();
        check_all("rearm");
        chk("rearm_done", 32'(bus.Done), 0);
        bus.Start = 0; bus.CurPc = PC_W'(900);
        tick();
        check_all("launch2");
        tick();
        for (int i = 1; i <= 7; i++) begin
            quiet();
            bus.CurPc = PC_W'(i);
            if (i == 3) bus.Start = 1;
            if (i == 7) bus.Halt = 1;
            check_all("run7");
            tick();
        end
        quiet();
        check_all("done7");
        chk("done7_cnt", 32'(bus.CycleCount), 7);
        tick();
        check_all("done7_stay");

        // Reset mid-run after 3 RUN cycles
        bus.Start = 1; bus.ProgSel = 2'd1;
        tick();
        bus.Start = 0;
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            check_all("run3");
            tick();
        end
        rst = 1'b1;
        check_all("rst_mid");
        tick();
        rst = 1'b0;
        check_all("after_rst");
        chk("after_rst_cnt", 32'(bus.CycleCount), 0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            rst          = ($urandom_range(0, 99) < 2);
            bus.Start    = ($urandom_range(0, 99) < 30);
            bus.ProgSel  = 2'($urandom_range(0, 3));
            bus.CurPc    = PC_W'($urandom);
            bus.BrTaken  = ($urandom_range(0, 99) < 35);
            bus.BrAbs    = 1'($urandom);
            bus.BrTarget = PC_W'($urandom);
            bus.Halt     = ($urandom_range(0, 99) < 6);
            bus.Stall    = ($urandom_range(0, 99) < 15);
            check_all("rand");
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_run_ctrl.md
Name: prog_run_ctrl

Overview:
- Run controller that sequences the program counter (ProgCtr) of the instruction-fetch stage.
- Holds the PC while idle, launches a selected program on the Start handshake, and converts decoder branch requests into the relative-offset form that ProgCtr consumes (PC <= PC + Target when Branch).
- Detects Halt, freezes fetch and reports Done plus a run-cycle count to the test harness.

Parameters:
- PC_W, 10, PC / target width.
- CNT_W, 16, CycleCount width.
- NUM_PROGS, 4, number of selectable programs; ProgSel width is $clog2(NUM_PROGS).

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  launch handshake from the harness.
- ProgSel  in  2  program index, latched on IDLE/DONE->ARMED.
- CurPc  in  PC_W  current ProgCtr output.
- BrTaken  in  1  branch taken this cycle.
- BrAbs  in  1  1 = BrTarget is absolute; 0 = BrTarget is a relative offset.
- BrTarget  in  PC_W  branch target or offset.
- Halt  in  1  halt instruction decoded this cycle.
- Stall  in  1  hold the PC this cycle (multi-cycle op).
- PcBranch  out  1  to ProgCtr Branch.
- PcTarget  out  PC_W  to ProgCtr Target (relative offset).
- PcHold  out  1  to ProgCtr hold; PC does not change when set.
- Running  out  1  high in RUN state.
- Done  out  1  high in DONE state.
- ActiveProg  out  2  latched program index.
- CycleCount  out  CNT_W  RUN cycles of the last or current run.

Behaviour:
- Reset (synchronous, active-high, overrides everything):
  - next state IDLE
  - PcHold=1, PcBranch=0, PcTarget=0, Running=0, Done=0, ActiveProg=0, CycleCount=0
  - Start is ignored while Reset=1.
- State is registered. PcBranch, PcTarget and PcHold are combinational from state and inputs (zero latency); ProgCtr registers them.
- Running and Done decode directly from state.
- States: IDLE, ARMED, LAUNCH, RUN, DONE.
- IDLE / DONE:
  - Outputs: PcHold=1, PcBranch=0, PcTarget=0.
  - Start=1 -> ARMED; latch ActiveProg=ProgSel. Done drops on leaving DONE.
- ARMED:
  - Outputs: PcHold=1.
  - Stay while Start=1; ProgSel changes are ignored.
  - Start=0 -> LAUNCH. A program therefore launches on Start deassertion.
- LAUNCH (exactly 1 cycle):
  - Outputs: PcHold=0, PcBranch=1, PcTarget = PROG_BASE[ActiveProg] - CurPc, modulo 2^PC_W.
  - Clear CycleCount. Next state RUN.
- RUN:
  - CycleCount += 1 every RUN cycle, including the Halt cycle; saturates at all-ones.
  - Priority per cycle: Halt > Stall > BrTaken > sequential.
  - Halt: PcHold=1, PcBranch=0; -> DONE. Simultaneous BrTaken and Stall are ignored.
  - Stall: PcHold=1, PcBranch=0; stay in RUN. A pending BrTaken is dropped; the decoder must re-present it.
  - BrTaken: PcHold=0, PcBranch=1.
    - PcTarget = BrAbs ? (BrTarget - CurPc) mod 2^PC_W : BrTarget.
    - Wrap-around is natural modulo arithmetic; no overflow flag.
  - Otherwise: PcHold=0, PcBranch=0, PcTarget=0; ProgCtr increments.
  - Start is ignored in RUN.
- DONE:
  - Done=1; CycleCount and ActiveProg hold.
  - A new Start restarts the sequence.
- Reset mid-RUN: IDLE on the next edge; the count is lost.
- PcTarget=0 whenever PcBranch=0.

Decomposition:
- Package prog_ctrl_pkg:
  - PC_W, NUM_PROGS
  - run_state_t enum (IDLE, ARMED, LAUNCH, RUN, DONE)
  - PROG_BASE constant array, default {0, 128, 256, 384}
- Sub-module pc_target_calc (combinational):
  - Inputs: mode (launch/abs/rel), base/target, CurPc.
  - Output: relative PcTarget.
- FSM and counter stay in prog_run_ctrl.

Test Plan:
- Reset: Reset=1 for 2 cycles, Start=1 during reset -> state IDLE, PcHold=1, PcBranch=0, Running=0, Done=0, CycleCount=0.
- Launch: ProgSel=2, Start=1 for 2 cycles, then 0, CurPc=5 -> LAUNCH cycle PcBranch=1, PcTarget=251; next cycle Running=1, ActiveProg=2. Changing ProgSel to 1 during ARMED has no effect.
- Branch conversion in RUN, each with PcBranch=1:
  - CurPc=260, BrAbs=0, BrTarget=10 -> PcTarget=10
  - BrAbs=1, BrTarget=300 -> PcTarget=40
  - CurPc=300, BrAbs=1, BrTarget=256 -> PcTarget=980 (wrap)
- Priority:
  - Stall=1 with BrTaken=1 -> PcHold=1, PcBranch=0, still RUN.
  - Halt=1 with BrTaken=1 -> PcBranch=0, PcHold=1, DONE next cycle.
- Halt count: 7 RUN cycles with Halt on the 7th, Start pulsed mid-run -> Done=1, CycleCount=7, PcHold=1, no relaunch. Start again from DONE -> ARMED, Done=0.
- Reset mid-RUN after 3 cycles -> IDLE next edge, CycleCount=0, Running=0, PcHold=1.
